// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART TX core among N_REQ byte
// requesters, with a start/busy handshake and a watchdog on busy rising.
// Optional build macro UART_ARB_TAG_EN: each transfer becomes a tag byte
// {4'hA, owner} followed by the data byte (requires DATA_W == 8).
module uart_tx_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 1024
)(
  input  logic                    CLK100MHZ,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        ack,
  output logic                    tx_start,
  output logic [DATA_W-1:0]       tx_data,
  input  logic                    tx_busy,
  output logic [3:0]              owner,
  output logic                    active,
  output logic                    err_timeout
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WW = $clog2(TIMEOUT);  // holds 0..TIMEOUT-1

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO} state_t;

  state_t                        state_q, state_d;
  logic [IW-1:0]                 ptr_q, ptr_d, own_q, own_d;
  logic [WW-1:0]                 wd_q, wd_d;
  logic [DATA_W-1:0]             txd_q, txd_d, dat_q, dat_d;
  logic                          tag_q, tag_d;  // 1 while the tag byte is in flight
  logic [N_REQ-1:0][DATA_W-1:0]  req_bytes;
  logic                          gnt_vld;
  logic [IW-1:0]                 gnt_idx, ptr_nxt;

  assign req_bytes = req_data;
  assign tx_data   = txd_q;
  assign owner     = 4'(own_q);
  assign active    = (state_q != IDLE);
  assign ptr_nxt   = (own_q == IW'(N_REQ-1)) ? '0 : own_q + IW'(1);

  // Round-robin pick: first set request scanning ptr, ptr+1, ... wrapping.
  always_comb begin
    int j;
    logic [IW-1:0] idx;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = N_REQ-1; k >= 0; k--) begin
      j = int'(ptr_q) + k;
      if (j >= N_REQ) j = j - N_REQ;
      idx = IW'(j);
      if (req[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  // Next-state and handshake outputs. The ack goes out with tx_start, so a
  // later watchdog expiry cannot retract it; recovery only moves the pointer.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    own_d       = own_q;
    wd_d        = wd_q;
    txd_d       = txd_q;
    dat_d       = dat_q;
    tag_d       = tag_q;
    tx_start    = 1'b0;
    ack         = '0;
    err_timeout = 1'b0;
    case (state_q)
      IDLE: begin
        // The core is only claimed when it is idle.
        if (gnt_vld && !tx_busy) begin
          own_d   = gnt_idx;
          dat_d   = req_bytes[gnt_idx];
          state_d = ISSUE;
`ifdef UART_ARB_TAG_EN
          tag_d   = 1'b1;
          txd_d   = {4'hA, 4'(gnt_idx)};
`else
          txd_d   = req_bytes[gnt_idx];
`endif
        end
      end
      ISSUE: begin
        tx_start = 1'b1;
        if (!tag_q) ack[own_q] = 1'b1;
        wd_d     = '0;
        state_d  = WAIT_HI;
      end
      WAIT_HI: begin
        if (tx_busy) begin
          state_d = WAIT_LO;
        end else if (wd_q == WW'(TIMEOUT-1)) begin
          // Stalled core: drop the transfer (tag or data) and move on.
          err_timeout = 1'b1;
          ptr_d       = ptr_nxt;
          tag_d       = 1'b0;
          state_d     = IDLE;
        end else begin
          wd_d = wd_q + WW'(1);
        end
      end
      WAIT_LO: begin
        if (!tx_busy) begin
          if (tag_q) begin
            // Tag byte done: send the data byte next.
            tag_d   = 1'b0;
            txd_d   = dat_q;
            state_d = ISSUE;
          end else begin
            ptr_d   = ptr_nxt;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      own_q   <= '0;
      wd_q    <= '0;
      txd_q   <= '0;
      dat_q   <= '0;
      tag_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      wd_q    <= wd_d;
      txd_q   <= txd_d;
      dat_q   <= dat_d;
      tag_q   <= tag_d;
    end
  end
endmodule
